// File: rtl/cpu_pkg.sv
// Shared RV32I decode types: op classes, immediate formats and base opcodes.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'h0,
    OP_ALU_I   = 4'h1,
    OP_LOAD    = 4'h2,
    OP_STORE   = 4'h3,
    OP_BRANCH  = 4'h4,
    OP_JAL     = 4'h5,
    OP_JALR    = 4'h6,
    OP_LUI     = 4'h7,
    OP_AUIPC   = 4'h8,
    OP_SYSTEM  = 4'h9,
    OP_ILLEGAL = 4'hF
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic op_class_e classify(input logic [6:0] opc);
    case (opc)
      OPC_OP:     classify = OP_ALU_R;
      OPC_OP_IMM: classify = OP_ALU_I;
      OPC_LOAD:   classify = OP_LOAD;
      OPC_STORE:  classify = OP_STORE;
      OPC_BRANCH: classify = OP_BRANCH;
      OPC_JAL:    classify = OP_JAL;
      OPC_JALR:   classify = OP_JALR;
      OPC_LUI:    classify = OP_LUI;
      OPC_AUIPC:  classify = OP_AUIPC;
      OPC_SYSTEM: classify = OP_SYSTEM;
      default:    classify = OP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired.
// Define CPU_IDECODE_WB_BYPASS_EN to make same-cycle writes visible on the read ports.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_mem [32];
  logic            w_wr;

  assign w_wr = i_we && (i_wa != 5'd0);

  // Contents intentionally not reset; x0 is masked on the read side.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[i_wa] <= i_wd;
  end

  always_comb begin
    o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
    o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];
`ifdef CPU_IDECODE_WB_BYPASS_EN
    if (w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
    if (w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
`endif
  end

endmodule

// File: rtl/cpu_idecode.sv
// RV32I decode stage: classify, build immediate, read operands, register for execute.
// Optional macro CPU_IDECODE_WB_BYPASS_EN: writeback bypass instead of a retry stall.
module cpu_idecode
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_inp_rdy,
  input  logic            f_valid,
  input  logic [31:0]     f_instr,
  input  logic [XLEN-1:0] f_pc,
  input  logic            e_j_flag,
  input  logic            w_en,
  input  logic [4:0]      w_rd,
  input  logic [XLEN-1:0] w_data,
  output logic            d_stall,
  output logic            d_valid,
  output logic [XLEN-1:0] d_pc,
  output logic [3:0]      d_op,
  output logic [2:0]      d_funct3,
  output logic            d_funct7b5,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [XLEN-1:0] d_rs1_val,
  output logic [XLEN-1:0] d_rs2_val,
  output logic [XLEN-1:0] d_imm,
  output logic            d_illegal
);

  op_class_e       w_op;
  imm_type_e       w_imm_type;
  logic [31:0]     w_imm;
  logic [4:0]      w_rd_f, w_rs1, w_rs2;
  logic            w_uses_rs1, w_uses_rs2;
  logic            w_slot_v, w_haz_ld, w_haz_wb, w_issue;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic            r_flush_q, r_ld_q;
  logic [4:0]      r_ld_rd;

  assign w_rs1 = f_instr[19:15];
  assign w_rs2 = f_instr[24:20];

  always_comb begin
    w_op       = classify(f_instr[6:0]);
    w_imm_type = IMM_NONE;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    w_rd_f     = f_instr[11:7];
    case (w_op)
      OP_ALU_R:  w_uses_rs2 = 1'b1;
      OP_ALU_I, OP_LOAD, OP_JALR, OP_SYSTEM: w_imm_type = IMM_I;
      OP_STORE:  begin w_imm_type = IMM_S; w_uses_rs2 = 1'b1; w_rd_f = 5'd0; end
      OP_BRANCH: begin w_imm_type = IMM_B; w_uses_rs2 = 1'b1; w_rd_f = 5'd0; end
      OP_JAL:    begin w_imm_type = IMM_J; w_uses_rs1 = 1'b0; end
      OP_LUI, OP_AUIPC: begin w_imm_type = IMM_U; w_uses_rs1 = 1'b0; end
      default:   w_imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    case (w_imm_type)
      IMM_I:   w_imm = {{20{f_instr[31]}}, f_instr[31:20]};
      IMM_S:   w_imm = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
      IMM_B:   w_imm = {{19{f_instr[31]}}, f_instr[31], f_instr[7], f_instr[30:25],
                        f_instr[11:8], 1'b0};
      IMM_U:   w_imm = {f_instr[31:12], 12'b0};
      IMM_J:   w_imm = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12], f_instr[20],
                        f_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // The cycle after a redirect fetch still presents a wrong-path slot.
  assign w_slot_v = f_valid & ~e_j_flag & ~r_flush_q;
  assign w_haz_ld = r_ld_q & ((w_uses_rs1 & (w_rs1 == r_ld_rd)) |
                              (w_uses_rs2 & (w_rs2 == r_ld_rd)));
`ifdef CPU_IDECODE_WB_BYPASS_EN
  assign w_haz_wb = 1'b0;
`else
  assign w_haz_wb = w_en & (w_rd != 5'd0) & ((w_uses_rs1 & (w_rs1 == w_rd)) |
                                             (w_uses_rs2 & (w_rs2 == w_rd)));
`endif
  assign d_stall = w_slot_v & (w_haz_ld | w_haz_wb);
  assign w_issue = w_slot_v & ~d_stall;

  cpu_regfile #(.XLEN(XLEN)) u_regfile (
    .clk   (clk),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rs1_val),
    .o_rd2 (w_rs2_val),
    .i_we  (w_en),
    .i_wa  (w_rd),
    .i_wd  (w_data)
  );

  // Decode -> execute register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid    <= 1'b0;
      d_pc       <= RESET_PC;
      d_op       <= '0;
      d_funct3   <= '0;
      d_funct7b5 <= 1'b0;
      d_rd       <= '0;
      d_rs1      <= '0;
      d_rs2      <= '0;
      d_rs1_val  <= '0;
      d_rs2_val  <= '0;
      d_imm      <= '0;
      d_illegal  <= 1'b0;
      r_flush_q  <= 1'b0;
      r_ld_q     <= 1'b0;
      r_ld_rd    <= '0;
    end else if (d_inp_rdy) begin
      d_valid    <= w_issue;
      d_pc       <= f_pc;
      d_op       <= w_op;
      d_funct3   <= f_instr[14:12];
      d_funct7b5 <= f_instr[30];
      d_rd       <= w_rd_f;
      d_rs1      <= w_rs1;
      d_rs2      <= w_rs2;
      d_rs1_val  <= w_rs1_val;
      d_rs2_val  <= w_rs2_val;
      d_imm      <= w_imm;
      d_illegal  <= w_issue & (w_op == OP_ILLEGAL);
      r_flush_q  <= e_j_flag;
      r_ld_q     <= w_issue & (w_op == OP_LOAD) & (w_rd_f != 5'd0);
      r_ld_rd    <= w_rd_f;
    end
  end

endmodule

// File: tb/tb_cpu_idecode.sv
// Directed bench for cpu_idecode: decode table plus hazard/redirect/reset sequences.
module tb_cpu_idecode;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_inp_rdy, f_valid, e_j_flag, w_en;
  logic [31:0] f_instr, f_pc, w_data;
  logic [4:0]  w_rd;
  logic        d_stall, d_valid, d_funct7b5, d_illegal;
  logic [31:0] d_pc, d_rs1_val, d_rs2_val, d_imm;
  logic [3:0]  d_op;
  logic [2:0]  d_funct3;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_idecode dut (
    .clk(clk), .rst(rst), .d_inp_rdy(d_inp_rdy), .f_valid(f_valid),
    .f_instr(f_instr), .f_pc(f_pc), .e_j_flag(e_j_flag),
    .w_en(w_en), .w_rd(w_rd), .w_data(w_data),
    .d_stall(d_stall), .d_valid(d_valid), .d_pc(d_pc), .d_op(d_op),
    .d_funct3(d_funct3), .d_funct7b5(d_funct7b5), .d_rd(d_rd),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val),
    .d_imm(d_imm), .d_illegal(d_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic        ill;
    logic        evld;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] instr, input logic [31:0] pc);
    f_valid = 1'b1;
    f_instr = instr;
    f_pc    = pc;
  endtask

  initial begin
    vecs[0]  = '{32'hFFD08113, 32'h100, 1'b1, OP_ALU_I,   5'd2, 5'd1, 32'hFFFFFFFD, 1'b0, 1'b1};
    vecs[1]  = '{32'h00118233, 32'h104, 1'b1, OP_ALU_R,   5'd4, 5'd3, 32'h00000000, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000A183, 32'h108, 1'b1, OP_LOAD,    5'd3, 5'd1, 32'h00000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h0020A423, 32'h10C, 1'b1, OP_STORE,   5'd0, 5'd1, 32'h00000008, 1'b0, 1'b1};
    vecs[4]  = '{32'h80000063, 32'h110, 1'b1, OP_BRANCH,  5'd0, 5'd0, 32'hFFFFF000, 1'b0, 1'b1};
    vecs[5]  = '{32'h002000EF, 32'h114, 1'b1, OP_JAL,     5'd1, 5'd0, 32'h00000002, 1'b0, 1'b1};
    vecs[6]  = '{32'hFFFFF2B7, 32'h118, 1'b1, OP_LUI,     5'd5, 5'd31, 32'hFFFFF000, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000000B, 32'h11C, 1'b1, OP_ILLEGAL, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{32'h0000000B, 32'h120, 1'b0, OP_ILLEGAL, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{32'h12345397, 32'h124, 1'b1, OP_AUIPC,   5'd7, 5'd8, 32'h12345000, 1'b0, 1'b1};
    vecs[10] = '{32'hFFF100E7, 32'h128, 1'b1, OP_JALR,    5'd1, 5'd2, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[11] = '{32'h00000073, 32'h12C, 1'b1, OP_SYSTEM,  5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};

    rst = 1'b1; d_inp_rdy = 1'b1; f_valid = 1'b0; e_j_flag = 1'b0;
    f_instr = '0; f_pc = '0; w_en = 1'b0; w_rd = '0; w_data = '0;
    #2;
    chk("reset_valid", {31'b0, d_valid}, 32'd0);
    chk("reset_pc", d_pc, 32'h0);
    chk("reset_imm", d_imm, 32'h0);
    chk("reset_op", {28'b0, d_op}, 32'h0);
    #10 rst = 1'b0;

    // Decode table: each vector followed by an idle slot.
    for (int i = 0; i < 12; i++) begin
      f_valid = vecs[i].vld; f_instr = vecs[i].instr; f_pc = vecs[i].pc;
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, d_valid}, {31'b0, vecs[i].evld});
      chk($sformatf("v%0d_illegal", i), {31'b0, d_illegal}, {31'b0, vecs[i].ill});
      if (vecs[i].evld) begin
        chk($sformatf("v%0d_op", i), {28'b0, d_op}, {28'b0, vecs[i].op});
        chk($sformatf("v%0d_rd", i), {27'b0, d_rd}, {27'b0, vecs[i].rd});
        chk($sformatf("v%0d_rs1", i), {27'b0, d_rs1}, {27'b0, vecs[i].rs1});
        chk($sformatf("v%0d_imm", i), d_imm, vecs[i].imm);
        chk($sformatf("v%0d_pc", i), d_pc, vecs[i].pc);
      end
      f_valid = 1'b0;
      tick();
    end

    // Writeback x1=5, then addi x2,x1,-3
    w_en = 1'b1; w_rd = 5'd1; w_data = 32'd5;
    tick();
    w_en = 1'b0;
    feed(32'hFFD08113, 32'h200);
    tick();
    chk("addi_valid", {31'b0, d_valid}, 32'd1);
    chk("addi_rs1_val", d_rs1_val, 32'd5);
    chk("addi_imm", d_imm, 32'hFFFFFFFD);
    chk("addi_rd", {27'b0, d_rd}, 32'd2);

    // Hold when d_inp_rdy is low
    d_inp_rdy = 1'b0;
    feed(32'hFFFFF2B7, 32'h204);
    tick();
    chk("hold_pc", d_pc, 32'h200);
    chk("hold_op", {28'b0, d_op}, {28'b0, OP_ALU_I});
    d_inp_rdy = 1'b1;
    f_valid = 1'b0;
    tick();

    // Load-use: lw x3,0(x1); add x4,x3,x1
    feed(32'h0000A183, 32'h300);
    tick();
    chk("lu_lw_valid", {31'b0, d_valid}, 32'd1);
    feed(32'h00118233, 32'h304);
    #1;
    chk("lu_stall", {31'b0, d_stall}, 32'd1);
    tick();
    chk("lu_bubble", {31'b0, d_valid}, 32'd0);
    chk("lu_stall_clear", {31'b0, d_stall}, 32'd0);
    tick();
    chk("lu_add_valid", {31'b0, d_valid}, 32'd1);
    chk("lu_add_rd", {27'b0, d_rd}, 32'd4);
    chk("lu_add_pc", d_pc, 32'h304);

    // Non-dependent follow-up
    feed(32'h0000A183, 32'h310);
    tick();
    feed(32'hFFD08113, 32'h314);
    #1;
    chk("nodep_stall", {31'b0, d_stall}, 32'd0);
    tick();
    chk("nodep_valid", {31'b0, d_valid}, 32'd1);

    // Redirect drops a pending load-use stall and squashes two advances
    feed(32'h0000A183, 32'h400);
    tick();
    feed(32'h00118233, 32'h404);
    e_j_flag = 1'b1;
    #1;
    chk("rd_stall_dropped", {31'b0, d_stall}, 32'd0);
    tick();
    e_j_flag = 1'b0;
    chk("rd_squash1", {31'b0, d_valid}, 32'd0);
    #1;
    chk("rd_shadow_stall", {31'b0, d_stall}, 32'd0);
    tick();
    chk("rd_squash2", {31'b0, d_valid}, 32'd0);
    feed(32'h00118233, 32'h800);
    tick();
    chk("rd_resume_valid", {31'b0, d_valid}, 32'd1);
    chk("rd_resume_pc", d_pc, 32'h800);

    // Same-cycle writeback of x5 read by addi x6,x5,0
    feed(32'h00028313, 32'h500);
    w_en = 1'b1; w_rd = 5'd5; w_data = 32'h0000ABCD;
    #1;
`ifdef CPU_IDECODE_WB_BYPASS_EN
    chk("wb_stall", {31'b0, d_stall}, 32'd0);
    tick();
    w_en = 1'b0;
`else
    chk("wb_stall", {31'b0, d_stall}, 32'd1);
    tick();
    w_en = 1'b0;
    chk("wb_bubble", {31'b0, d_valid}, 32'd0);
    #1;
    chk("wb_retry_stall", {31'b0, d_stall}, 32'd0);
    tick();
`endif
    chk("wb_valid", {31'b0, d_valid}, 32'd1);
    chk("wb_rs1_val", d_rs1_val, 32'h0000ABCD);

    // Asynchronous reset mid-stream
    feed(32'hFFD08113, 32'h600);
    tick();
    chk("mid_pre_valid", {31'b0, d_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, d_valid}, 32'd0);
    chk("mid_rst_pc", d_pc, 32'h0);
    chk("mid_rst_imm", d_imm, 32'h0);
    #1 rst = 1'b0;
    feed(32'hFFFFF2B7, 32'h700);
    tick();
    chk("post_rst_valid", {31'b0, d_valid}, 32'd1);
    chk("post_rst_op", {28'b0, d_op}, {28'b0, OP_LUI});
    chk("post_rst_imm", d_imm, 32'hFFFFF000);
    f_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_idecode.md
Name: cpu_idecode

Overview:
- Decode stage directly downstream of instruction fetch; consumes the aligned fetch triple (f_instr, f_pc, fetch output-valid).
- Classifies RV32I opcodes, generates the sign-extended immediate and reads rs1/rs2 from the integrated 32x32 register file.
- Registers the result for execute one cycle later.
- Detects load-use hazards, stalls fetch, and squashes wrong-path slots on an execute redirect.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0, d_pc value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- d_inp_rdy  in  1  advance enable; the output register updates only when high.
- f_valid  in  1  fetch slot valid (fetch i_otp_rdy).
- f_instr  in  32  fetched instruction.
- f_pc  in  32  PC of f_instr.
- e_j_flag  in  1  execute redirect/flush.
- w_en  in  1  writeback write enable.
- w_rd  in  5  writeback destination.
- w_data  in  32  writeback data.
- d_stall  out  1  combinational; top drives fetch i_inp_rdy = d_inp_rdy & ~d_stall.
- d_valid  out  1  decoded slot valid.
- d_pc  out  32  PC of decoded slot.
- d_op  out  4  op class (package enum).
- d_funct3  out  3  instr[14:12].
- d_funct7b5  out  1  instr[30].
- d_rd  out  5  destination; forced to 0 for STORE/BRANCH.
- d_rs1  out  5  source 1 index.
- d_rs2  out  5  source 2 index.
- d_rs1_val  out  32  rs1 data.
- d_rs2_val  out  32  rs2 data.
- d_imm  out  32  sign-extended immediate.
- d_illegal  out  1  unknown opcode in a valid slot.

Behaviour:
- Reset: all registered outputs are 0, d_pc=RESET_PC, flush_q=0, ld_q=0. Register file contents are not reset, except x0, which always reads 0.
- Latency: one clk from fetch triple to d_* outputs.
- When d_inp_rdy=0, every register holds its value, including flush_q and ld_q.
- Slot-valid rule: slot_v = f_valid & ~e_j_flag & ~flush_q.
- flush_q <= e_j_flag on each advance. This squashes the stale slot fetch presents the cycle after a redirect.
- Load-use detection: ld_q/ld_rd record that the currently output slot is a valid LOAD with rd != 0.
- d_stall = slot_v & ld_q & ((uses_rs1 & rs1==ld_rd) | (uses_rs2 & rs2==ld_rd)).
- On a stall, the output is a bubble (d_valid=0) and ld_q clears. The same f_instr is decoded again next cycle and issues.
- Redirect priority: e_j_flag overrides a stall. d_stall is gated by slot_v, so it is 0 during a redirect.
- Op classes by opcode:
  - 0110011 ALU_R
  - 0010011 ALU_I
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - 1110011 SYSTEM
  - anything else is ILLEGAL.
- Immediates:
  - I-type: instr[31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
  - All sign-extend from bit 31. ALU_R and ILLEGAL give imm=0.
- uses_rs1: all classes except JAL, LUI, AUIPC. uses_rs2: ALU_R, STORE, BRANCH.
- Register file: written on the clk edge when w_en and w_rd!=0; writes to x0 are dropped. The write port operates regardless of d_inp_rdy.
- Invalid slot: d_valid=0 and d_illegal=0; other fields are don't-care but deterministic.

Optional Feature:
- Macro: CPU_IDECODE_WB_BYPASS_EN.
- Defined: a read whose index equals w_rd, with w_en=1 and w_rd!=0, returns w_data in the same cycle (write-through).
- Undefined: no bypass. d_stall also asserts for one cycle when slot_v & w_en & w_rd!=0 and w_rd matches a used source; the read retries after the write lands.

Decomposition:
- Package cpu_pkg holds:
  - op_class_e enum (4-bit, ILLEGAL=4'hF).
  - Opcode localparams OPC_*.
  - imm_type_e (I, S, B, U, J, NONE).
- Sub-module cpu_regfile: 2 async read ports, 1 sync write port, x0 hardwired, bypass under the macro.
- Immediate generation and classification stay combinational inside cpu_idecode.

Test Plan:
1. Reset mid-stream: assert rst while d_valid=1 -> all outputs clear immediately (async); d_pc=0; next slot decodes normally.
2. Arithmetic immediate: write x1=5 via writeback; feed addi x2,x1,-3 (32'hFFD08113) -> d_op=ALU_I, d_rs1_val=5, d_imm=32'hFFFFFFFD, d_rd=2.
3. Load-use: lw x3,0(x1) then add x4,x3,x1 -> one bubble cycle with d_stall=1 and d_valid=0; add issues next cycle; a non-dependent sequence has no stall.
4. Redirect: e_j_flag=1 for one cycle -> d_valid=0 for two consecutive advances (flush_q shadow); a pending load-use stall is dropped.
5. Immediate corners: beq offset -4096 -> d_imm=32'hFFFFF000; jal +2 -> d_imm=2; lui 0xFFFFF -> d_imm=32'hFFFFF000; opcode 7'b0001011 -> d_illegal=1.
6. WB same-cycle read of x5: with the macro, d_rs1_val=w_data and no stall; without it, one stall cycle then the new value.
